nlfsr_tap_feedback: RTL and testbench

//  Parametrised NLFSR feedback unit: holds a run-time loaded table of tap indices,

---
 rtl/nlfsr_pkg.sv | 21 ++
 rtl/nlfsr_tap_feedback_if.sv | 21 ++
 rtl/nlfsr_tap_mux.sv | 17 +
 rtl/nlfsr_tap_feedback.sv | 124 ++++++++++++
 tb/tb_nlfsr_tap_feedback.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nlfsr_pkg.sv
// Shared types and defaults for the NLFSR tap feedback unit.
// State encoding, mode constants and default parameter values.
package nlfsr_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ARMED,
    S_RUN
  } state_t;

  localparam logic MODE_LIN    = 1'b0;
  localparam logic MODE_NONLIN = 1'b1;

  localparam int DEF_NUM_OF_TAPS = 15;
  localparam int DEF_SIZE        = 32;
  localparam int DEF_IDX_W       = 8;
  localparam int DEF_NONLIN_TAPS = 6;
  localparam int DEF_AND_PAIRS   = 1;

endpackage

// File: rtl/nlfsr_tap_feedback_if.sv
// Coefficient load channel between the loader and the feedback unit.
// Valid/ready handshake plus last marker and sticky error status.
interface nlfsr_tap_feedback_if #(
  parameter int IDX_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [IDX_W-1:0] cfg_data;
  logic             cfg_last;
  logic             cfg_error;

  modport master (
    output cfg_valid, cfg_data, cfg_last,
    input  cfg_ready, cfg_error
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_last,
    output cfg_ready, cfg_error
  );
endinterface

// File: rtl/nlfsr_tap_mux.sv
// Selects one NLFSR state bit by tap index.
// Indices outside the register width read as zero.
module nlfsr_tap_mux #(
  parameter int SIZE  = 32,
  parameter int IDX_W = 8
) (
  input  logic [SIZE-1:0]  register,
  input  logic [IDX_W-1:0] idx,
  output logic             sel
);
  localparam int SEL_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic in_range;

  assign in_range = int'(idx) < SIZE;
  assign sel = in_range ? register[idx[SEL_W-1:0]] : 1'b0;
endmodule

// File: rtl/nlfsr_tap_feedback.sv
// NLFSR feedback unit: run-time tap table, tap sampling stage
// and a registered linear / nonlinear feedback stage.
module nlfsr_tap_feedback
  import nlfsr_pkg::*;
#(
  parameter int NUM_OF_TAPS = DEF_NUM_OF_TAPS,
  parameter int SIZE        = DEF_SIZE,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int NONLIN_TAPS = DEF_NONLIN_TAPS,
  parameter int AND_PAIRS   = DEF_AND_PAIRS
) (
  input  logic                clk,
  input  logic                res,
  nlfsr_tap_feedback_if.slave cfg,
  input  logic                start,
  input  logic                mode,
  input  logic [SIZE-1:0]     register,
  output logic                result,
  output logic                result_valid
);
  localparam int PTR_W = $clog2(NUM_OF_TAPS + 1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_END = PTR_W'(NUM_OF_TAPS);

  state_t           state, state_n;
  logic [PTR_W-1:0] ptr, ptr_n;
  logic             err_q, err_n;
  logic [IDX_W-1:0] coef [1:NUM_OF_TAPS];

  logic xfer, first, at_end, oor;

  logic [NUM_OF_TAPS:1] tap_bit, t_q;
  logic mode_q, v1, f_val, lin, nl;

  assign cfg.cfg_ready = res && (state != S_RUN);
  assign cfg.cfg_error = err_q;

  assign xfer   = cfg.cfg_valid && cfg.cfg_ready;
  assign first  = (state == S_IDLE) || (state == S_ARMED);
  assign at_end = (ptr == PTR_END);
  assign oor    = int'(cfg.cfg_data) >= SIZE;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    err_n   = err_q;
    if (xfer) begin
      err_n = (first ? 1'b0 : err_q) | oor;
      // last must coincide exactly with the final slot
      if (at_end != cfg.cfg_last) begin
        err_n   = 1'b1;
        state_n = S_IDLE;
        ptr_n   = PTR_ONE;
      end else if (at_end) begin
        state_n = S_ARMED;
        ptr_n   = PTR_ONE;
      end else begin
        state_n = S_LOAD;
        ptr_n   = ptr + 1'b1;
      end
    end else begin
      unique case (state)
        S_ARMED: if (start)  state_n = S_RUN;
        S_RUN:   if (!start) state_n = S_ARMED;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= S_IDLE;
      ptr   <= PTR_ONE;
      err_q <= 1'b0;
      for (int i = 1; i <= NUM_OF_TAPS; i++)
        coef[i] <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      err_q <= err_n;
      if (xfer) coef[ptr] <= cfg.cfg_data;
    end
  end

  for (genvar i = 1; i <= NUM_OF_TAPS; i++) begin : g_tap
    nlfsr_tap_mux #(
      .SIZE  (SIZE),
      .IDX_W (IDX_W)
    ) u_mux (
      .register (register),
      .idx      (coef[i]),
      .sel      (tap_bit[i])
    );
  end

  always_comb begin
    lin = ^t_q;
    nl  = 1'b0;
    for (int k = 1; k <= AND_PAIRS; k++)
      nl = nl ^ (t_q[NONLIN_TAPS-2*k+2]
               & t_q[NONLIN_TAPS-2*k+1]);
    for (int i = 1; i <= NONLIN_TAPS - 2*AND_PAIRS; i++)
      nl = nl ^ t_q[i];
    f_val = (mode_q == MODE_NONLIN) ? nl : lin;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      t_q          <= '0;
      mode_q       <= MODE_LIN;
      v1           <= 1'b0;
      result       <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      v1 <= (state == S_RUN);
      if (state == S_RUN) begin
        t_q    <= tap_bit;
        mode_q <= mode;
      end
      result_valid <= v1;
      if (v1) result <= f_val;
    end
  end
endmodule

// File: tb/tb_nlfsr_tap_feedback.sv
// Directed bench for nlfsr_tap_feedback with a reference model
// and an expected-result queue checked every clock.
module tb_nlfsr_tap_feedback;
  import nlfsr_pkg::*;

  logic        clk;
  logic        res;
  logic        start;
  logic        mode;
  logic [31:0] register;
  logic        result;
  logic        result_valid;

  nlfsr_tap_feedback_if #(.IDX_W(8)) cif ();

  nlfsr_tap_feedback dut (
    .clk          (clk),
    .res          (res),
    .cfg          (cif),
    .start        (start),
    .mode         (mode),
    .register     (register),
    .result       (result),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v;
    logic r;
  } exp_t;

  exp_t   q[$];
  state_t ms;
  int     mptr;
  logic [7:0] mcoef [1:15];
  logic   merr;
  logic   mres;
  int     total;
  int     bad;
  int     npulse;

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs,
                         input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic f_model();
    logic t [1:15];
    logic a;
    for (int i = 1; i <= 15; i++)
      t[i] = (mcoef[i] < 32) ? register[mcoef[i][4:0]] : 1'b0;
    a = 1'b0;
    if (mode == 1'b0) begin
      for (int i = 1; i <= 15; i++) a = a ^ t[i];
    end else begin
      a = (t[6] & t[5]) ^ t[4] ^ t[3] ^ t[2] ^ t[1];
    end
    return a;
  endfunction

  task automatic model_clear();
    ms   = S_IDLE;
    mptr = 1;
    merr = 1'b0;
    mres = 1'b0;
    for (int i = 1; i <= 15; i++) mcoef[i] = 8'h00;
    q.delete();
  endtask

  task automatic step();
    exp_t   it;
    state_t ns;
    int     np;
    logic   ne;
    logic   xf;
    it.v = (ms == S_RUN);
    it.r = it.v ? f_model() : 1'b0;
    xf = cif.cfg_valid && (ms != S_RUN);
    ns = ms;
    np = mptr;
    ne = merr;
    if (xf) begin
      ne = ((ms == S_IDLE || ms == S_ARMED) ? 1'b0 : merr)
         | (cif.cfg_data >= 8'd32);
      if ((mptr == 15) != cif.cfg_last) begin
        ne = 1'b1;
        ns = S_IDLE;
        np = 1;
      end else if (mptr == 15) begin
        ns = S_ARMED;
        np = 1;
      end else begin
        ns = S_LOAD;
        np = mptr + 1;
      end
      mcoef[mptr] = cif.cfg_data;
    end else if (ms == S_ARMED && start) begin
      ns = S_RUN;
    end else if (ms == S_RUN && !start) begin
      ns = S_ARMED;
    end
    @(posedge clk);
    #1;
    ms   = ns;
    mptr = np;
    merr = ne;
    q.push_back(it);
    if (q.size() >= 2) begin
      it = q.pop_front();
      if (it.v) mres = it.r;
      chk("result_valid", result_valid, it.v);
      chk("result", result, mres);
    end
    chk("cfg_ready", cif.cfg_ready, ms != S_RUN);
    chk("cfg_error", cif.cfg_error, merr);
    if (result_valid === 1'b1) npulse++;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    cif.cfg_valid = 1'b1;
    cif.cfg_data  = d;
    cif.cfg_last  = l;
    step();
    cif.cfg_valid = 1'b0;
    cif.cfg_last  = 1'b0;
  endtask

  task automatic load_std();
    for (int i = 1; i <= 15; i++)
      send(8'(i), i == 15);
  endtask

  task automatic do_reset(input string tag);
    #3;
    res = 1'b0;
    #1;
    chk({tag, "_result"}, result, 1'b0);
    chk({tag, "_valid"}, result_valid, 1'b0);
    chk({tag, "_ready"}, cif.cfg_ready, 1'b0);
    chk({tag, "_error"}, cif.cfg_error, 1'b0);
    @(posedge clk);
    #3;
    res = 1'b1;
    model_clear();
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    npulse        = 0;
    res           = 1'b0;
    start         = 1'b0;
    mode          = 1'b0;
    register      = 32'h0;
    cif.cfg_valid = 1'b0;
    cif.cfg_data  = 8'h00;
    cif.cfg_last  = 1'b0;
    model_clear();

    #3;
    chk("rst_result", result, 1'b0);
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_ready", cif.cfg_ready, 1'b0);
    chk("rst_error", cif.cfg_error, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    res = 1'b1;
    step();

    // 1: basic load then run, nonlinear mode
    load_std();
    register = 32'h0000_003F;
    mode     = 1'b1;
    start    = 1'b1;
    repeat (4) step();

    // 2: linear / nonlinear, then mode toggled each cycle
    register = 32'h0000_001E;
    mode     = 1'b0;
    repeat (3) step();
    mode = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 8; i++) begin
      mode     = i[0];
      register = (i < 4) ? 32'h0000_0046 : 32'h0000_807E;
      step();
    end

    // 5: exactly ten samples, cfg blocked while running
    start = 1'b0;
    repeat (4) step();
    start = 1'b1;
    step();
    npulse        = 0;
    cif.cfg_valid = 1'b1;
    cif.cfg_data  = 8'h05;
    for (int i = 0; i < 9; i++) begin
      register = $urandom();
      mode     = 1'($urandom_range(0, 1));
      step();
    end
    start = 1'b0;
    step();
    cif.cfg_valid = 1'b0;
    repeat (4) step();
    chk_int("run_pulses", npulse, 10);

    // 3: early last, missing last, start ignored in IDLE
    for (int i = 1; i <= 7; i++) send(8'(i), i == 7);
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    for (int i = 1; i <= 15; i++) send(8'(i), 1'b0);
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;

    // 4: out-of-range index, tap reads zero
    for (int i = 1; i <= 15; i++)
      send((i == 3) ? 8'h40 : 8'(i), i == 15);
    start = 1'b1;
    mode  = 1'b0;
    register = 32'hFFFF_FFFF;
    repeat (3) step();
    mode = 1'b1;
    register = 32'h0000_0008;
    repeat (3) step();
    register = 32'h0000_0010;
    repeat (3) step();
    start = 1'b0;
    repeat (3) step();
    send(8'h01, 1'b0);
    for (int i = 2; i <= 15; i++) send(8'(i), i == 15);

    // 6: reset mid-load and mid-run
    send(8'h40, 1'b0);
    send(8'h02, 1'b0);
    do_reset("rst_load");
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    load_std();
    register = 32'h0000_0002;
    mode     = 1'b0;
    start    = 1'b1;
    repeat (4) step();
    chk("pre_rst_result", result, 1'b1);
    do_reset("rst_run");
    repeat (3) step();
    load_std();
    repeat (4) step();
    start = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
